// File: rtl/ldpc_ctrl_pkg.sv
// Shared types and defaults for the LDPC min-sum iteration controller.
package ldpc_ctrl_pkg;

  localparam int DEF_N      = 12;
  localparam int DEF_M      = 6;
  localparam int DEF_ITER_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROW,
    S_COL,
    S_CHK,
    S_SYN,
    S_DONE
  } state_t;

  // Flat H-matrix position of (check m, bit n).
  function automatic int h_idx(
    input int m,
    input int n,
    input int n_w
  );
    return m * n_w + n;
  endfunction

endpackage

// File: rtl/ldpc_syndrome.sv
// Parity syndrome of a hard-decision estimate against matrix H.
module ldpc_syndrome
  import ldpc_ctrl_pkg::*;
#(
  parameter int              N = DEF_N,
  parameter int              M = DEF_M,
  parameter logic [M*N-1:0]  H = '1
) (
  input  logic [N-1:0] i_est,
  output logic [M-1:0] o_syn
);

  always_comb begin
    o_syn = '0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        o_syn[m] = o_syn[m] ^ (H[h_idx(m, n, N)] & i_est[n]);
      end
    end
  end

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC iteration controller: row/column phase sequencing, syndrome-based
// early termination and a valid/ready result handshake.
module ldpc_iter_ctrl
  import ldpc_ctrl_pkg::*;
#(
  parameter int              N        = DEF_N,
  parameter int              M        = DEF_M,
  parameter logic [M*N-1:0]  H        = '1,
  parameter int              MAX_ITER = 100,
  parameter int              ITER_W   = DEF_ITER_W,
  parameter int              ROW_LAT  = 2,
  parameter int              COL_LAT  = 2
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              i_val,
  output logic              o_ready,
  output logic              o_load,
  output logic              o_row_en,
  output logic              o_col_en,
  input  logic              i_est_val,
  input  logic [N-1:0]      i_estimate,
  output logic              o_val,
  input  logic              i_ready,
  output logic [N-1:0]      o_estimate,
  output logic [ITER_W-1:0] o_iter,
  output logic              o_converged
);

  localparam int PH_MAX = (ROW_LAT > COL_LAT) ? ROW_LAT : COL_LAT;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_t              r_state;
  state_t              w_nxt;
  logic [PH_W-1:0]     r_phase;
  logic [ITER_W-1:0]   r_iter;
  logic [N-1:0]        r_est;
  logic                r_conv;
  logic [M-1:0]        w_syn;
  logic                w_row_last;
  logic                w_col_last;
  logic                w_syn_zero;
  logic                w_iter_max;

  ldpc_syndrome #(
    .N (N),
    .M (M),
    .H (H)
  ) u_syn (
    .i_est (r_est),
    .o_syn (w_syn)
  );

  assign w_row_last = (r_phase == PH_W'(ROW_LAT - 1));
  assign w_col_last = (r_phase == PH_W'(COL_LAT - 1));
  assign w_syn_zero = (w_syn == '0);
  assign w_iter_max = (r_iter == ITER_W'(MAX_ITER));

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (i_val)      w_nxt = S_LOAD;
      S_LOAD:                 w_nxt = S_ROW;
      S_ROW:  if (w_row_last) w_nxt = S_COL;
      S_COL:  if (w_col_last) w_nxt = S_CHK;
      S_CHK:  if (i_est_val)  w_nxt = S_SYN;
      S_SYN: begin
        if (w_syn_zero || w_iter_max) w_nxt = S_DONE;
        else                          w_nxt = S_ROW;
      end
      S_DONE: if (i_ready)    w_nxt = S_IDLE;
      default:                w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      r_phase <= '0;
      r_iter  <= '0;
      r_est   <= '0;
      r_conv  <= 1'b0;
    end else begin
      // Phase counter runs only while a phase holds its own state.
      if ((r_state == S_ROW && !w_row_last) ||
          (r_state == S_COL && !w_col_last))
        r_phase <= r_phase + PH_W'(1);
      else
        r_phase <= '0;
      if (r_state == S_IDLE && i_val)
        r_iter <= '0;
      else if (r_state == S_COL && w_col_last)
        r_iter <= r_iter + ITER_W'(1);
      if (r_state == S_CHK && i_est_val)
        r_est <= i_estimate;
      if (r_state == S_SYN && w_nxt == S_DONE)
        r_conv <= w_syn_zero;
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_load      = (r_state == S_LOAD);
  assign o_row_en    = (r_state == S_ROW);
  assign o_col_en    = (r_state == S_COL);
  assign o_val       = (r_state == S_DONE);
  assign o_estimate  = r_est;
  assign o_iter      = r_iter;
  assign o_converged = r_conv;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl with a 6-bit, 3-check code.
module tb_ldpc_iter_ctrl;

  localparam int N  = 6;
  localparam int M  = 3;
  localparam int IW = 7;
  // checks: {b0,b1,b3}, {b1,b2,b4}, {b0,b2,b5}
  localparam logic [M*N-1:0] HM = 18'b100101_010110_001011;

  logic          clk = 1'b0;
  logic          xrst;
  logic          i_val;
  logic          o_ready;
  logic          o_load;
  logic          o_row_en;
  logic          o_col_en;
  logic          i_est_val;
  logic [N-1:0]  i_estimate;
  logic          o_val;
  logic          i_ready;
  logic [N-1:0]  o_estimate;
  logic [IW-1:0] o_iter;
  logic          o_converged;

  int pass_cnt = 0;
  int total    = 0;

  ldpc_iter_ctrl #(
    .N        (N),
    .M        (M),
    .H        (HM),
    .MAX_ITER (3),
    .ITER_W   (IW),
    .ROW_LAT  (2),
    .COL_LAT  (2)
  ) dut (
    .clk         (clk),
    .xrst        (xrst),
    .i_val       (i_val),
    .o_ready     (o_ready),
    .o_load      (o_load),
    .o_row_en    (o_row_en),
    .o_col_en    (o_col_en),
    .i_est_val   (i_est_val),
    .i_estimate  (i_estimate),
    .o_val       (o_val),
    .i_ready     (i_ready),
    .o_estimate  (o_estimate),
    .o_iter      (o_iter),
    .o_converged (o_converged)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_val(input int budget, output int rows, output int cols);
    int e;
    e = 0;
    rows = 0;
    cols = 0;
    while (!o_val && e < budget) begin
      step();
      e++;
      if (o_row_en) rows++;
      if (o_col_en) cols++;
    end
    total++;
    if (o_val !== 1'b1) $display("FAIL wait_val timeout o_val=%b need 1", o_val);
    else pass_cnt++;
  endtask

  task automatic start_frame(input logic [N-1:0] est);
    i_estimate = est;
    i_val = 1'b1;
    step();
    i_val = 1'b0;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    int r;
    int c;
    xrst = 1'b1;
    i_val = 1'b1;
    i_ready = 1'b0;
    i_est_val = 1'b1;
    i_estimate = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_ready, o_load, o_row_en, o_col_en, o_val, o_converged} !== 6'b100000) begin
      $display("FAIL reset_ctl got %b need 100000",
               {o_ready, o_load, o_row_en, o_col_en, o_val, o_converged});
    end else pass_cnt++;
    total++;
    if (o_estimate !== 6'd0 || o_iter !== 7'd0)
      $display("FAIL reset_data est=%b iter=%0d need 0/0", o_estimate, o_iter);
    else pass_cnt++;
    xrst = 1'b0;
    step();
    total++;
    if (o_load !== 1'b1) $display("FAIL reset_load got %b need 1", o_load);
    else pass_cnt++;
    i_val = 1'b0;
    step();
    total++;
    if (o_load !== 1'b0) $display("FAIL reset_load_once got %b need 0", o_load);
    else pass_cnt++;
    wait_val(40, r, c);
    drain();
  endtask

  task automatic test_converge_first();
    int rows;
    int cols;
    int vedge;
    rows = 0;
    cols = 0;
    vedge = 0;
    i_estimate = 6'b000000;
    i_val = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      i_val = 1'b0;
      if (o_row_en) rows++;
      if (o_col_en) cols++;
      if (o_val && vedge == 0) vedge = k;
    end
    total++;
    if (vedge !== 8) $display("FAIL conv1_latency got %0d need 8", vedge);
    else pass_cnt++;
    total++;
    if (rows !== 2 || cols !== 2)
      $display("FAIL conv1_phase rows=%0d cols=%0d need 2/2", rows, cols);
    else pass_cnt++;
    total++;
    if (o_iter !== 7'd1 || o_converged !== 1'b1 || o_estimate !== 6'b000000)
      $display("FAIL conv1_result iter=%0d conv=%b est=%b need 1/1/000000",
               o_iter, o_converged, o_estimate);
    else pass_cnt++;
    drain();
    total++;
    if (o_ready !== 1'b1 || o_val !== 1'b0)
      $display("FAIL conv1_handoff ready=%b val=%b need 1/0", o_ready, o_val);
    else pass_cnt++;
  endtask

  task automatic test_max_iter();
    int r;
    int c;
    start_frame(6'b000001);
    wait_val(60, r, c);
    total++;
    if (r !== 6 || c !== 6)
      $display("FAIL max_phase rows=%0d cols=%0d need 6/6", r, c);
    else pass_cnt++;
    total++;
    if (o_iter !== 7'd3 || o_converged !== 1'b0 || o_estimate !== 6'b000001)
      $display("FAIL max_result iter=%0d conv=%b est=%b need 3/0/000001",
               o_iter, o_converged, o_estimate);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_late_converge();
    int r;
    int c;
    start_frame(6'b000001);
    repeat (6) step();
    i_estimate = 6'b110011;
    wait_val(60, r, c);
    total++;
    if (o_iter !== 7'd2 || o_converged !== 1'b1 || o_estimate !== 6'b110011)
      $display("FAIL late_result iter=%0d conv=%b est=%b need 2/1/110011",
               o_iter, o_converged, o_estimate);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    int r;
    int c;
    logic stable;
    start_frame(6'b110011);
    wait_val(40, r, c);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_val = (k == 2);
      step();
      if (o_val !== 1'b1 || o_ready !== 1'b0 || o_estimate !== 6'b110011 ||
          o_iter !== 7'd1 || o_converged !== 1'b1)
        stable = 1'b0;
    end
    i_val = 1'b0;
    total++;
    if (stable !== 1'b1) $display("FAIL bp_stable got %b need 1", stable);
    else pass_cnt++;
    i_val = 1'b1;
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    total++;
    if (o_ready !== 1'b1 || o_val !== 1'b0)
      $display("FAIL bp_release ready=%b val=%b need 1/0", o_ready, o_val);
    else pass_cnt++;
    i_estimate = 6'b000000;
    step();
    i_val = 1'b0;
    total++;
    if (o_load !== 1'b1) $display("FAIL bp_accept load=%b need 1", o_load);
    else pass_cnt++;
    wait_val(40, r, c);
    drain();
  endtask

  task automatic test_mid_reset();
    int r;
    int c;
    start_frame(6'b000001);
    repeat (8) step();
    total++;
    if (o_row_en !== 1'b1 || o_iter !== 7'd1)
      $display("FAIL mr_pre row=%b iter=%0d need 1/1", o_row_en, o_iter);
    else pass_cnt++;
    #2 xrst = 1'b1;
    #1;
    total++;
    if (o_row_en !== 1'b0 || o_iter !== 7'd0 || o_ready !== 1'b1)
      $display("FAIL mr_async row=%b iter=%0d ready=%b need 0/0/1",
               o_row_en, o_iter, o_ready);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    xrst = 1'b0;
    step();
    total++;
    if (o_val !== 1'b0 || o_ready !== 1'b1)
      $display("FAIL mr_idle val=%b ready=%b need 0/1", o_val, o_ready);
    else pass_cnt++;
    start_frame(6'b000000);
    total++;
    if (o_load !== 1'b1) $display("FAIL mr_load got %b need 1", o_load);
    else pass_cnt++;
    wait_val(40, r, c);
    total++;
    if (o_iter !== 7'd1 || o_converged !== 1'b1)
      $display("FAIL mr_result iter=%0d conv=%b need 1/1", o_iter, o_converged);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_converge_first();
    test_max_iter();
    test_late_converge();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
